pipe_addsub: RTL

Parametrised, pipelined adder/subtractor that generalises the team's 4-bit combinational full adder. It supports any width, a selectable add or subtract mode and carry/borrow chaining. The carry ripples one SLICE_W-bit slice per clock stage, with a valid/ready handshake on both sides. It sits in datapaths where wide additions must close timing at full clock rate and sustain one operation per cycle.

---
 rtl/pipe_addsub_pkg.sv | 17 +
 rtl/addsub_slice.sv | 21 ++
 rtl/pipe_addsub.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_addsub_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
// Stage count and slice-width legality are computed here so every user agrees on them.
package pipe_addsub_pkg;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_SLICE_W = 4;

    function automatic int calc_stages(input int width, input int slice_w);
        return width / slice_w;
    endfunction

    // Width must split into a whole, non-zero number of slices.
    function automatic bit slices_ok(input int width, input int slice_w);
        return (slice_w > 0) && (width >= slice_w) && ((width % slice_w) == 0);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE_W-bit ripple slice: sum, carry-out and carry into the slice MSB.
module addsub_slice #(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               c_msb
);

    logic [SLICE_W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
    assign s     = total[SLICE_W-1:0];
    assign cout  = total[SLICE_W];
    // The carry into the MSB is recoverable from the MSB sum bit, which also works for 1-bit slices.
    assign c_msb = s[SLICE_W-1] ^ a[SLICE_W-1] ^ b[SLICE_W-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: one SLICE_W-bit slice of the carry chain per stage,
// whole pipe advances together under a single valid/ready handshake.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SLICE_W = DEFAULT_SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, SLICE_W);

    if (!slices_ok(WIDTH, SLICE_W)) begin : g_bad_width
        $error("pipe_addsub: WIDTH must be a non-zero multiple of SLICE_W");
    end

    logic              adv;
    logic [STAGES-1:0] vld_r;
    logic [STAGES-1:0] cy_r;
    logic [STAGES-1:0] sb_r;
    logic              ovf_r;
    logic [WIDTH-1:0]  sum_r [STAGES];
    logic [WIDTH-1:0]  a_r   [STAGES];
    logic [WIDTH-1:0]  b_r   [STAGES];

    logic [STAGES-1:0]  st_v;
    logic [STAGES-1:0]  st_c;
    logic [STAGES-1:0]  st_sb;
    logic [STAGES-1:0]  sl_co;
    logic [STAGES-1:0]  sl_cm;
    logic [WIDTH-1:0]   st_a   [STAGES];
    logic [WIDTH-1:0]   st_b   [STAGES];
    logic [WIDTH-1:0]   st_sum [STAGES];
    logic [WIDTH-1:0]   nx_sum [STAGES];
    logic [SLICE_W-1:0] sl_s   [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Operands are stored pre-shifted so the next slice to consume always sits in the low bits;
    // B is stored already inverted for subtract.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign st_v[k]   = in_valid;
            assign st_a[k]   = a;
            assign st_b[k]   = sub ? ~b : b;
            assign st_c[k]   = c_in ^ sub;
            assign st_sb[k]  = sub;
            assign st_sum[k] = '0;
        end else begin : g_next
            assign st_v[k]   = vld_r[k-1];
            assign st_a[k]   = a_r[k-1];
            assign st_b[k]   = b_r[k-1];
            assign st_c[k]   = cy_r[k-1];
            assign st_sb[k]  = sb_r[k-1];
            assign st_sum[k] = sum_r[k-1];
        end

        addsub_slice #(.SLICE_W(SLICE_W)) u_slice (
            .a     (st_a[k][SLICE_W-1:0]),
            .b     (st_b[k][SLICE_W-1:0]),
            .cin   (st_c[k]),
            .s     (sl_s[k]),
            .cout  (sl_co[k]),
            .c_msb (sl_cm[k])
        );

        assign nx_sum[k] = st_sum[k] | (WIDTH'(sl_s[k]) << (k * SLICE_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= '0;
            cy_r  <= '0;
            sb_r  <= '0;
            ovf_r <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                sum_r[k] <= '0;
                a_r[k]   <= '0;
                b_r[k]   <= '0;
            end
        end else if (adv) begin
            vld_r <= st_v;
            cy_r  <= sl_co;
            sb_r  <= st_sb;
            ovf_r <= sl_cm[STAGES-1] ^ sl_co[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                sum_r[k] <= nx_sum[k];
                a_r[k]   <= st_a[k] >> SLICE_W;
                b_r[k]   <= st_b[k] >> SLICE_W;
            end
        end
    end

    assign out_valid = vld_r[STAGES-1];
    assign sum       = sum_r[STAGES-1];
    assign c_out     = cy_r[STAGES-1] ^ sb_r[STAGES-1];
    assign ovf       = ovf_r;

    // Leftover operand bits of the last stage and the inner slices' MSB carries have no consumer.
    logic unused_bits;
    assign unused_bits = ^{a_r[STAGES-1], b_r[STAGES-1], sl_cm};

endmodule
